// File: rtl/uart_frame_tx.sv
// Sends a fixed 14-byte frame (0x55, 12 payload bytes LSB-byte first, 0xAA) as 8N1 serial, back-to-back bytes.
// uart_txd and busy follow an accepted frame_start by one clock; frame_start is ignored while busy.
module uart_frame_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        frame_start,
    input  logic [95:0] frame_data,
    output logic        busy,
    output logic        frame_done,
    output logic        uart_txd
);
    localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);
    localparam logic [3:0] LAST_BYTE = 4'd13;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [3:0]       byte_idx_q, byte_idx_d;
    logic [95:0]      data_q, data_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [111:0]     frame_vec;
    logic [7:0]       cur_byte;

    // Whole frame as one vector so byte_idx selects header, payload and tail uniformly.
    assign frame_vec = {8'hAA, data_q, 8'h55};
    assign cur_byte  = frame_vec[{byte_idx_q, 3'b000} +: 8];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        data_d     = data_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (state_q == IDLE) begin
            txd_d  = 1'b1;
            busy_d = 1'b0;
            if (frame_start) begin
                data_d     = frame_data;
                state_d    = START;
                bit_cnt_d  = '0;
                bit_idx_d  = '0;
                byte_idx_d = '0;
                txd_d      = 1'b0;
                busy_d     = 1'b1;
            end
        end else if (bit_cnt_q != CNT_LAST) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
            // Bit boundary: the next line level is decided here so txd only moves on boundaries.
            bit_cnt_d = '0;
            case (state_q)
                START: begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    txd_d     = cur_byte[0];
                end
                DATA: begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = cur_byte[bit_idx_q + 3'd1];
                    end
                end
                STOP: begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d    = IDLE;
                        byte_idx_d = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        txd_d      = 1'b1;
                    end else begin
                        state_d    = START;
                        byte_idx_d = byte_idx_q + 4'd1;
                        txd_d      = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            data_q     <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            data_q     <= data_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign uart_txd   = txd_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx at 10 clocks per bit; decodes the serial line cycle by cycle.
module tb_uart_frame_tx;
    localparam int B  = 10;
    localparam int NB = 140 * B;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic [95:0] fd;
    logic        busy, done, txd;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    uart_frame_tx #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
        .sys_clk(clk), .sys_rst(rst), .frame_start(fs), .frame_data(fd),
        .busy(busy), .frame_done(done), .uart_txd(txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at the negedge where busy is first high (cycle 0 of the frame) and returns at the frame_done negedge.
    task automatic rx_frame(output logic [139:0] bits, output logic [111:0] bytes,
                            output int glitches, output int ferr, output int dur);
        int w;
        w = 0; bits = '0; bytes = '0; glitches = 0; ferr = 0; dur = -1;
        while (busy !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("rx_busy_seen", busy, 1);
        if (busy === 1'b1) begin
            for (int idx = 0; idx <= NB + 20; idx++) begin
                if (idx > 0) @(negedge clk);
                if (idx < NB) begin
                    if (idx % B == 0) bits[idx / B] = txd;
                    else if (txd !== bits[idx / B]) glitches++;
                end
                if (done === 1'b1 && dur < 0) dur = idx;
                if (idx >= NB && dur >= 0) break;
            end
        end
        for (int k = 0; k < 14; k++) begin
            if (bits[10*k] !== 1'b0 || bits[10*k+9] !== 1'b1) ferr++;
            bytes[8*k +: 8] = bits[10*k+1 +: 8];
        end
    endtask

    logic [139:0] bits, bits2;
    logic [111:0] got, got2;
    int gl, fe, dur, gl2, fe2, dur2, c0;

    initial begin
        logic [111:0] exp_basic;
        exp_basic = 112'hAA_0C_FF_00_00_00_00_44_00_03_01_01_01_55;
        rst = 1'b1; fs = 1'b0; fd = '0;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        fs = 1'b1;
        fd = 96'hFFFF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ignores_start", busy, 0);
        fs = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_txd", txd, 1);

        // Basic frame, latency, bit order
        c0 = done_cnt;
        fd = 96'h0C_FF_00_00_00_00_44_00_03_01_01_01;
        fs = 1'b1;
        chk("pre_busy", busy, 0);
        @(negedge clk);
        fs = 1'b0;
        chk("lat_busy", busy, 1);
        chk("lat_txd", txd, 0);
        rx_frame(bits, got, gl, fe, dur);
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("basic_byte%0d", k), got[8*k +: 8], exp_basic[8*k +: 8]);
        end
        chk("basic_glitch", gl, 0);
        chk("basic_framing", fe, 0);
        chk("basic_dur", dur, 1400);
        chk("basic_busy_at_done", busy, 0);
        chk("bit_order_byte1", bits[19:10], 10'b1000000010);
        repeat (3) @(negedge clk);
        chk("basic_done_once", done_cnt - c0, 1);

        // Second request at clock 300 is ignored
        c0 = done_cnt;
        fd = 96'hA1A2A3A4_B1B2B3B4_C1C2C3C4;
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        fork
            rx_frame(bits, got, gl, fe, dur);
            begin
                repeat (300) @(negedge clk);
                fd = 96'h11111111_22222222_33333333;
                fs = 1'b1;
                @(negedge clk);
                fs = 1'b0;
            end
        join
        chk("rej_bytes", got, 112'hAA_A1A2A3A4_B1B2B3B4_C1C2C3C4_55);
        chk("rej_dur", dur, 1400);
        repeat (5) @(negedge clk);
        chk("rej_done_once", done_cnt - c0, 1);
        chk("rej_idle", busy, 0);

        // Back-to-back with frame_start held high; data changes mid-frame
        c0 = done_cnt;
        fd = 96'h0102030405060708090A0B0C;
        fs = 1'b1;
        @(negedge clk);
        fork
            rx_frame(bits, got, gl, fe, dur);
            begin
                repeat (700) @(negedge clk);
                fd = 96'hF0E0D0C0B0A0908070605040;
            end
        join
        chk("b2b_gap_txd", txd, 1);
        @(negedge clk);
        chk("b2b_busy2", busy, 1);
        chk("b2b_start2", txd, 0);
        fs = 1'b0;
        rx_frame(bits2, got2, gl2, fe2, dur2);
        chk("b2b_frame1", got, 112'hAA_0102030405060708090A0B0C_55);
        chk("b2b_frame2", got2, 112'hAA_F0E0D0C0B0A0908070605040_55);
        chk("b2b_dur2", dur2, 1400);
        chk("b2b_framing", fe + fe2 + gl + gl2, 0);
        repeat (5) @(negedge clk);
        chk("b2b_done_twice", done_cnt - c0, 2);

        // Reset during byte 5
        c0 = done_cnt;
        fd = 96'h5A5A5A5A_5A5A5A5A_5A5A5A5A;
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        repeat (525) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_busy", busy, 0);
        fs = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        fs = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", busy, 0);
        chk("post_rst_no_done", done_cnt - c0, 0);
        fd = 96'h123456789ABCDEF012345678;
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        rx_frame(bits, got, gl, fe, dur);
        chk("post_rst_bytes", got, 112'hAA_123456789ABCDEF012345678_55);
        chk("post_rst_dur", dur, 1400);

        // Loopback of an incrementing payload
        fd = 96'h1D1C1B1A_19181716_15141312;
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        rx_frame(bits, got, gl, fe, dur);
        chk("loop_payload", got[95+8:8], 96'h1D1C1B1A_19181716_15141312);
        chk("loop_framing", fe + gl, 0);
        chk("loop_dur", dur, 1400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
